// File: rtl/alu_dispatch_pkg.sv
// Shared types and constants for the SM83 ALU dispatch front end.
// Decode helper maps an instruction byte onto ALU control and operand routing.
package alu_dispatch_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_READ_A   = 4'd1;
  localparam state_t S_READ_SRC = 4'd2;
  localparam state_t S_MEM_RD   = 4'd3;
  localparam state_t S_EXEC     = 4'd4;
  localparam state_t S_CARRY    = 4'd5;
  localparam state_t S_WB       = 4'd6;
  localparam state_t S_MEM_WR   = 4'd7;
  localparam state_t S_ILL      = 4'd8;

  localparam logic [2:0] REG_B  = 3'd0;
  localparam logic [2:0] REG_C  = 3'd1;
  localparam logic [2:0] REG_D  = 3'd2;
  localparam logic [2:0] REG_E  = 3'd3;
  localparam logic [2:0] REG_H  = 3'd4;
  localparam logic [2:0] REG_L  = 3'd5;
  localparam logic [2:0] IDX_HL = 3'd6;
  localparam logic [2:0] REG_A  = 3'd7;

  localparam logic [3:0] CNTR_ADD = 4'd0;
  localparam logic [3:0] CNTR_SUB = 4'd1;
  localparam logic [3:0] CNTR_AND = 4'd2;
  localparam logic [3:0] CNTR_OR  = 4'd3;
  localparam logic [3:0] CNTR_XOR = 4'd4;
  localparam logic [3:0] CNTR_INC = 4'd11;
  localparam logic [3:0] CNTR_DEC = 4'd12;
  localparam logic [3:0] CNTR_SET = 4'd13;
  localparam logic [3:0] CNTR_RES = 4'd14;
  localparam logic [3:0] CNTR_BIT = 4'd15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    GRP_NONE,
    GRP_ADD,
    GRP_SUB,
    GRP_AND,
    GRP_OR,
    GRP_INC,
    GRP_DEC,
    GRP_BIT,
    GRP_RES,
    GRP_SET
  } grp_t;

  typedef struct packed {
    grp_t       grp;
    logic [3:0] cntr;
    logic       two;
    logic       carry;
    logic       wr;
    logic [2:0] src;
    logic [2:0] tgt;
    logic [2:0] bidx;
  } dec_t;

  // GRP_NONE marks an unsupported byte
  function automatic dec_t decode(
    input logic       cb,
    input logic [7:0] op
  );
    dec_t d;
    d = '0;
    d.grp = GRP_NONE;
    if (cb) begin
      d.src  = op[2:0];
      d.tgt  = op[2:0];
      d.bidx = op[5:3];
      unique case (op[7:6])
        2'b01: begin
          d.grp  = GRP_BIT;
          d.cntr = CNTR_BIT;
        end
        2'b10: begin
          d.grp  = GRP_RES;
          d.cntr = CNTR_RES;
          d.wr   = 1'b1;
        end
        2'b11: begin
          d.grp  = GRP_SET;
          d.cntr = CNTR_SET;
          d.wr   = 1'b1;
        end
        default: ;
      endcase
    end else if (op[7:6] == 2'b10) begin
      d.two   = 1'b1;
      d.src   = op[2:0];
      d.tgt   = REG_A;
      d.wr    = (op[5:3] != 3'd7);
      d.carry = (op[5:3] == 3'd1) || (op[5:3] == 3'd3);
      unique case (op[5:3])
        3'd0, 3'd1: begin
          d.grp  = GRP_ADD;
          d.cntr = CNTR_ADD;
        end
        3'd4: begin
          d.grp  = GRP_AND;
          d.cntr = CNTR_AND;
        end
        3'd5: begin
          d.grp  = GRP_OR;
          d.cntr = CNTR_XOR;
        end
        3'd6: begin
          d.grp  = GRP_OR;
          d.cntr = CNTR_OR;
        end
        default: begin
          d.grp  = GRP_SUB;
          d.cntr = CNTR_SUB;
        end
      endcase
    end else if (op[7:6] == 2'b00 && op[2:1] == 2'b10) begin
      d.src = op[5:3];
      d.tgt = op[5:3];
      d.wr  = 1'b1;
      if (op[0]) begin
        d.grp  = GRP_DEC;
        d.cntr = CNTR_DEC;
      end else begin
        d.grp  = GRP_INC;
        d.cntr = CNTR_INC;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_dispatch_flag_gen.sv
// Next-flag computation for the dispatch block.
// H and C come from widened sums so the 8-bit ALU need not export carries.
module alu_flag_gen
  import alu_dispatch_pkg::*;
(
  input  grp_t       grp,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic [7:0] res,
  output logic [3:0] nxt,
  output logic [3:0] mask
);

  logic [8:0] sum;
  logic [8:0] dif;
  logic [4:0] hsum;
  logic [4:0] hdif;
  logic       zero;

  assign sum  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
  assign dif  = {1'b0, a} - {1'b0, b} - {8'b0, cin};
  assign hsum = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign hdif = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
  assign zero = (res == 8'h00);

  always_comb begin
    nxt  = '0;
    mask = '0;
    nxt[FLAG_Z] = zero;
    unique case (grp)
      GRP_ADD: begin
        mask        = 4'hF;
        nxt[FLAG_H] = hsum[4];
        nxt[FLAG_C] = sum[8];
      end
      GRP_SUB: begin
        mask        = 4'hF;
        nxt[FLAG_N] = 1'b1;
        nxt[FLAG_H] = hdif[4];
        nxt[FLAG_C] = dif[8];
      end
      GRP_AND: begin
        mask        = 4'hF;
        nxt[FLAG_H] = 1'b1;
      end
      GRP_OR: mask = 4'hF;
      GRP_INC: begin
        mask        = 4'b1110;
        nxt[FLAG_H] = (a[3:0] == 4'hF);
      end
      GRP_DEC: begin
        mask        = 4'b1110;
        nxt[FLAG_N] = 1'b1;
        nxt[FLAG_H] = (a[3:0] == 4'h0);
      end
      GRP_BIT: begin
        mask        = 4'b1110;
        nxt[FLAG_Z] = ~a[b[2:0]];
        nxt[FLAG_H] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_dispatch.sv
// Sequential front end for the 8-bit ALU: operand fetch from
// the register file or (HL), ALU sequencing, flags and writeback.
module alu_dispatch
  import alu_dispatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       opValid,
  output logic       opReady,
  input  logic [7:0] opcode,
  input  logic       cbPrefix,
  output logic [2:0] regRdAddr,
  input  logic [7:0] regRdData,
  output logic       regWrEn,
  output logic [2:0] regWrAddr,
  output logic [7:0] regWrData,
  output logic       memReq,
  output logic       memWe,
  output logic [7:0] memWdata,
  input  logic [7:0] memRdata,
  input  logic       memAck,
  output logic [7:0] aluA,
  output logic [7:0] aluB,
  output logic [3:0] aluCntr,
  input  logic [7:0] aluResult,
  output logic [3:0] flags,
  output logic       illegal
);

  state_t     state;
  dec_t       dec;
  dec_t       op;
  logic [7:0] opa;
  logic [7:0] opb;
  logic [7:0] res;
  logic       req;
  logic       cin;
  logic [7:0] fetch;
  logic [7:0] bsel;
  logic [3:0] fl_nxt;
  logic [3:0] fl_mask;

  assign dec   = decode(cbPrefix, opcode);
  assign cin   = op.carry & flags[FLAG_C];
  assign fetch = (state == S_MEM_RD) ? memRdata : regRdData;
  assign bsel  = op.two ? opb : {5'b0, op.bidx};

  alu_flag_gen u_flag_gen (
    .grp  (op.grp),
    .a    (opa),
    .b    (bsel),
    .cin  (cin),
    .res  (res),
    .nxt  (fl_nxt),
    .mask (fl_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      flags <= '0;
      req   <= 1'b0;
      op    <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (opValid) begin
            op <= dec;
            if (dec.grp == GRP_NONE)
              state <= S_ILL;
            else if (dec.two)
              state <= S_READ_A;
            else
              state <= S_READ_SRC;
          end
        end
        S_READ_A: begin
          opa   <= regRdData;
          state <= S_READ_SRC;
        end
        S_READ_SRC: begin
          if (op.src == IDX_HL) begin
            state <= S_MEM_RD;
          end else begin
            if (op.two) opb <= fetch;
            else        opa <= fetch;
            state <= S_EXEC;
          end
        end
        // request rises one cycle after entry, drops with the ack
        S_MEM_RD: begin
          if (!req) begin
            req <= 1'b1;
          end else if (memAck) begin
            req <= 1'b0;
            if (op.two) opb <= fetch;
            else        opa <= fetch;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res   <= aluResult;
          state <= cin ? S_CARRY : S_WB;
        end
        S_CARRY: begin
          res   <= aluResult;
          state <= S_WB;
        end
        S_WB: begin
          flags <= (flags & ~fl_mask) | (fl_nxt & fl_mask);
          if (op.wr && op.tgt == IDX_HL)
            state <= S_MEM_WR;
          else
            state <= S_IDLE;
        end
        S_MEM_WR: begin
          if (!req) begin
            req <= 1'b1;
          end else if (memAck) begin
            req   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    opReady   = (state == S_IDLE);
    regRdAddr = '0;
    aluA      = '0;
    aluB      = '0;
    aluCntr   = '0;
    regWrEn   = 1'b0;
    regWrAddr = '0;
    regWrData = '0;
    memReq    = req;
    memWe     = 1'b0;
    memWdata  = '0;
    illegal   = (state == S_ILL);
    unique case (state)
      S_READ_A: regRdAddr = REG_A;
      S_READ_SRC: begin
        if (op.src != IDX_HL) regRdAddr = op.src;
      end
      S_EXEC: begin
        aluA    = opa;
        aluB    = bsel;
        aluCntr = op.cntr;
      end
      // carry-in applied as a second pass through INC/DEC
      S_CARRY: begin
        aluA    = res;
        aluCntr = (op.grp == GRP_SUB) ? CNTR_DEC : CNTR_INC;
      end
      S_WB: begin
        regWrEn   = op.wr && (op.tgt != IDX_HL) && !reset;
        regWrAddr = op.tgt;
        regWrData = res;
      end
      S_MEM_WR: begin
        memWe    = req;
        memWdata = res;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized bench for alu_dispatch against an SM83 instruction-level model,
// with behavioural ALU, register file and (HL) memory around the DUT.
module tb_alu_dispatch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       opValid = 1'b0;
  logic       opReady;
  logic [7:0] opcode = 8'h00;
  logic       cbPrefix = 1'b0;
  logic [2:0] regRdAddr;
  logic [7:0] regRdData;
  logic       regWrEn;
  logic [2:0] regWrAddr;
  logic [7:0] regWrData;
  logic       memReq;
  logic       memWe;
  logic [7:0] memWdata;
  logic [7:0] memRdata;
  logic       memAck;
  logic [7:0] aluA;
  logic [7:0] aluB;
  logic [3:0] aluCntr;
  logic [7:0] aluResult;
  logic [3:0] flags;
  logic       illegal;

  logic [7:0] rf [8];
  logic [7:0] memv;
  logic       ld_en = 1'b0;
  logic [2:0] ld_idx = 3'd0;
  logic [7:0] ld_val = 8'h00;
  int         ack_dly = 1;
  int         mcnt = 0;

  logic [7:0] m_rf [8];
  logic [7:0] m_mem;
  logic [3:0] m_fl;

  int errors = 0;
  int checks = 0;

  alu_dispatch dut (
    .clk       (clk),
    .reset     (reset),
    .opValid   (opValid),
    .opReady   (opReady),
    .opcode    (opcode),
    .cbPrefix  (cbPrefix),
    .regRdAddr (regRdAddr),
    .regRdData (regRdData),
    .regWrEn   (regWrEn),
    .regWrAddr (regWrAddr),
    .regWrData (regWrData),
    .memReq    (memReq),
    .memWe     (memWe),
    .memWdata  (memWdata),
    .memRdata  (memRdata),
    .memAck    (memAck),
    .aluA      (aluA),
    .aluB      (aluB),
    .aluCntr   (aluCntr),
    .aluResult (aluResult),
    .flags     (flags),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  assign regRdData = rf[regRdAddr];
  assign memRdata  = memv;
  assign memAck    = memReq && (mcnt == ack_dly - 1);

  always @(posedge clk) begin
    if (memReq && !memAck) mcnt <= mcnt + 1;
    else                   mcnt <= 0;
    if (memReq && memAck && memWe) memv <= memWdata;
    if (regWrEn) rf[regWrAddr] <= regWrData;
    if (ld_en) begin
      if (ld_idx == 3'd6) memv <= ld_val;
      else                rf[ld_idx] <= ld_val;
    end
  end

  // external 8-bit ALU
  always_comb begin
    aluResult = 8'h00;
    case (aluCntr)
      4'd0:  aluResult = aluA + aluB;
      4'd1:  aluResult = aluA - aluB;
      4'd2:  aluResult = aluA & aluB;
      4'd3:  aluResult = aluA | aluB;
      4'd4:  aluResult = aluA ^ aluB;
      4'd11: aluResult = aluA + 8'd1;
      4'd12: aluResult = aluA - 8'd1;
      4'd13: aluResult = aluA | (8'd1 << aluB[2:0]);
      4'd14: aluResult = aluA & ~(8'd1 << aluB[2:0]);
      4'd15: aluResult = aluA;
      default: aluResult = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_dut();
    return {rf[0], rf[1], rf[2], rf[3], rf[4], rf[5], rf[7], memv};
  endfunction

  function automatic logic [63:0] pack_model();
    return {m_rf[0], m_rf[1], m_rf[2], m_rf[3], m_rf[4], m_rf[5],
            m_rf[7], m_mem};
  endfunction

  function automatic logic [7:0] rd(input int idx);
    return (idx == 6) ? m_mem : m_rf[idx];
  endfunction

  task automatic set_reg(input int idx, input logic [7:0] v);
    @(negedge clk);
    ld_en  = 1'b1;
    ld_idx = 3'(idx);
    ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
    if (idx == 6) m_mem = v;
    else          m_rf[idx] = v;
  endtask

  // instruction-level SM83 model: new state, latency, bus activity
  task automatic model(input bit cb, input logic [7:0] op, input int d,
                       output int lat, output bit ill, output bit wr,
                       output int mrq);
    int a, b, ci, r, bi, t, s;
    bit z, n, h, c, dow;
    logic [7:0] v;
    {z, n, h, c} = m_fl;
    lat = 0; ill = 0; wr = 0; mrq = 0;
    dow = 0; t = 0; r = 0;
    if (cb) begin
      s = int'(op[2:0]); bi = int'(op[5:3]); t = s;
      v = rd(s);
      lat = 4;
      if (s == 6) begin lat += 1 + d; mrq += d; end
      case (op[7:6])
        2'd1: begin z = !v[bi]; n = 0; h = 1; end
        2'd2: begin r = int'(v) & ~(1 << bi); dow = 1; end
        2'd3: begin r = int'(v) | (1 << bi); dow = 1; end
        default: ill = 1;
      endcase
    end else if (op[7:6] == 2'b10) begin
      s = int'(op[2:0]); t = 7;
      a = int'(m_rf[7]); b = int'(rd(s));
      ci = (op[5:3] == 3'd1 || op[5:3] == 3'd3) ? int'(c) : 0;
      lat = 5 + ci;
      if (s == 6) begin lat += 1 + d; mrq += d; end
      case (op[5:3])
        3'd0, 3'd1: begin
          r = a + b + ci; n = 0; dow = 1;
          h = ((a % 16) + (b % 16) + ci) > 15;
          c = (a + b + ci) > 255;
        end
        3'd4: begin r = a & b; n = 0; h = 1; c = 0; dow = 1; end
        3'd5: begin r = a ^ b; n = 0; h = 0; c = 0; dow = 1; end
        3'd6: begin r = a | b; n = 0; h = 0; c = 0; dow = 1; end
        default: begin
          r = a - b - ci; n = 1;
          h = (a % 16) < ((b % 16) + ci);
          c = a < (b + ci);
          dow = (op[5:3] != 3'd7);
        end
      endcase
      z = ((r & 255) == 0);
    end else if (op[7:6] == 2'b00 && (op[2:0] == 3'd4 || op[2:0] == 3'd5)) begin
      s = int'(op[5:3]); t = s;
      a = int'(rd(s));
      lat = 4;
      if (s == 6) begin lat += 1 + d; mrq += d; end
      if (op[0] == 1'b0) begin r = a + 1; n = 0; h = (a % 16) == 15; end
      else               begin r = a - 1; n = 1; h = (a % 16) == 0; end
      z = ((r & 255) == 0);
      dow = 1;
    end else begin
      ill = 1;
    end
    if (ill) begin
      lat = 2; mrq = 0;
    end else begin
      m_fl = {z, n, h, c};
      if (dow) begin
        if (t == 6) begin
          m_mem = 8'(r); lat += 1 + d; mrq += d;
        end else begin
          m_rf[t] = 8'(r); wr = 1;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input bit cb,
                        input logic [7:0] op, input int d);
    int e_lat, e_mrq;
    bit e_ill, e_wr;
    int lat, wr_n, wr_at, mr_n, il_n, il_at;
    lat = 0; wr_n = 0; wr_at = 0; mr_n = 0; il_n = 0; il_at = 0;
    ack_dly = d;
    model(cb, op, d, e_lat, e_ill, e_wr, e_mrq);
    @(negedge clk);
    check({tag, " ready"}, 64'(opReady), 64'd1);
    opValid  = 1'b1;
    opcode   = op;
    cbPrefix = cb;
    @(posedge clk);
    #1;
    opValid  = 1'b0;
    opcode   = 8'h00;
    cbPrefix = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (regWrEn) begin wr_n++; wr_at = i; end
      if (memReq) mr_n++;
      if (illegal) begin il_n++; il_at = i; end
      if (opReady) begin lat = i; break; end
    end
    check({tag, " latency"}, 64'(lat), 64'(e_lat));
    check({tag, " illegal"}, 64'(il_n), 64'(e_ill));
    if (e_ill) check({tag, " ill_cycle"}, 64'(il_at), 64'd1);
    check({tag, " wr_count"}, 64'(wr_n), 64'(e_wr));
    if (e_wr) check({tag, " wr_cycle"}, 64'(wr_at), 64'(e_lat - 1));
    check({tag, " memreq"}, 64'(mr_n), 64'(e_mrq));
    check({tag, " flags"}, 64'(flags), 64'(m_fl));
    check({tag, " state"}, pack_dut(), pack_model());
  endtask

  task automatic reset_mid_op();
    ack_dly = 50;
    @(negedge clk);
    opValid = 1'b1; opcode = 8'hBE; cbPrefix = 1'b0;
    @(posedge clk);
    #1;
    opValid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst memreq_before", 64'(memReq), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_fl = 4'h0;
    @(negedge clk);
    check("rst memreq", 64'(memReq), 64'd0);
    check("rst ready", 64'(opReady), 64'd1);
    check("rst flags", 64'(flags), 64'd0);
    check("rst state", pack_dut(), pack_model());
    ack_dly = 1;
  endtask

  initial begin
    int k, d;
    logic [7:0] op;
    bit cb;
    m_fl = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(opReady), 64'd1);
    check("reset flags", 64'(flags), 64'd0);
    check("reset memreq", 64'(memReq), 64'd0);
    check("reset wren", 64'(regWrEn), 64'd0);
    check("reset illegal", 64'(illegal), 64'd0);
    check("reset cntr", 64'(aluCntr), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) set_reg(i, 8'($urandom));

    set_reg(7, 8'h3A); set_reg(0, 8'hC6);
    run_op("add", 1'b0, 8'h80, 1);
    check("add a", 64'(rf[7]), 64'h00);
    check("add fl", 64'(flags), 64'hB);

    set_reg(7, 8'hE1); set_reg(1, 8'h0F);
    run_op("adc", 1'b0, 8'h89, 1);
    check("adc a", 64'(rf[7]), 64'hF1);
    check("adc fl", 64'(flags), 64'h2);

    set_reg(7, 8'h3C); set_reg(6, 8'h40);
    run_op("cp", 1'b0, 8'hBE, 3);
    check("cp fl", 64'(flags), 64'h5);

    set_reg(6, 8'h80);
    run_op("set", 1'b1, 8'hC6, 2);
    check("set mem", 64'(memv), 64'h81);
    check("set fl", 64'(flags), 64'h5);

    set_reg(7, 8'h7F);
    run_op("bit", 1'b1, 8'h7F, 1);
    check("bit fl", 64'(flags), 64'hB);

    set_reg(7, 8'hFF);
    run_op("inc", 1'b0, 8'h3C, 1);
    check("inc a", 64'(rf[7]), 64'h00);
    check("inc fl", 64'(flags), 64'hB);

    run_op("ill", 1'b1, 8'h00, 1);

    for (int i = 0; i < 80; i++) begin
      set_reg($urandom_range(0, 7), 8'($urandom));
      k  = $urandom_range(0, 3);
      d  = $urandom_range(1, 3);
      op = 8'($urandom);
      cb = 1'b0;
      case (k)
        0: op = {2'b10, op[5:0]};
        1: op = {2'b00, op[5:3], 2'b10, op[0]};
        2: cb = 1'b1;
        default: ;
      endcase
      run_op("rnd", cb, op, d);
    end

    reset_mid_op();
    run_op("post_rst", 1'b0, 8'h80, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
